// File: rtl/normalize_shift_ctrl.sv
// Post-add/sub mantissa normaliser: leading-zero count, left shift and exponent
// adjust, with clamping to the denormal range when the exponent runs out.
module normalize_shift_ctrl #(
   parameter int W  = 55,
   parameter int EW = 11,
   parameter int CW = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   input  logic [W-1:0]  mant_i,
   input  logic [EW-1:0] exp_i,
   output logic          ready_o,
   output logic          valid_o,
   input  logic          ack_i,
   output logic [W-1:0]  mant_o,
   output logic [EW-1:0] exp_o,
   output logic [CW-1:0] shift_o,
   output logic          zero_o,
   output logic          underflow_o
);

   typedef enum logic [1:0] {S_IDLE, S_ENCODE, S_SHIFT, S_DONE} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [W-1:0]  r_mant;
   logic [EW-1:0] r_exp;
   logic [CW-1:0] r_lz;
   logic          r_zf;

   logic [CW-1:0] w_lz;
   logic          w_zf;
   logic [EW-1:0] w_lz_ext;
   logic          w_uf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start_i) w_next = S_ENCODE;
         S_ENCODE: w_next = S_SHIFT;
         S_SHIFT:  w_next = S_DONE;
         S_DONE:   if (ack_i) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   assign ready_o = (r_state == S_IDLE);
   assign valid_o = (r_state == S_DONE);

   // Scan upward so the highest set bit wins; all-zero leaves W-1.
   always_comb begin
      w_lz = CW'(W - 1);
      for (int i = 0; i < W; i++)
         if (r_mant[i]) w_lz = CW'(W - 1 - i);
   end

   assign w_zf     = (r_mant == '0);
   assign w_lz_ext = {{(EW-CW){1'b0}}, r_lz};
   assign w_uf     = (w_lz_ext > r_exp);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mant      <= '0;
         r_exp       <= '0;
         r_lz        <= '0;
         r_zf        <= 1'b0;
         mant_o      <= '0;
         exp_o       <= '0;
         shift_o     <= '0;
         zero_o      <= 1'b0;
         underflow_o <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (start_i) begin
               r_mant <= mant_i;
               r_exp  <= exp_i;
            end
            S_ENCODE: begin
               r_lz <= w_lz;
               r_zf <= w_zf;
            end
            S_SHIFT: begin
               zero_o      <= r_zf;
               underflow_o <= !r_zf && w_uf;
               if (r_zf) begin
                  mant_o  <= '0;
                  exp_o   <= '0;
                  shift_o <= '0;
               end else if (w_uf) begin
                  // exp_r < lz <= W-1 here, so the low CW bits hold the whole amount
                  mant_o  <= r_mant << r_exp;
                  exp_o   <= '0;
                  shift_o <= r_exp[CW-1:0];
               end else begin
                  mant_o  <= r_mant << r_lz;
                  exp_o   <= r_exp - w_lz_ext;
                  shift_o <= r_lz;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_normalize_shift_ctrl.sv
// Scoreboard bench for normalize_shift_ctrl: driver pushes hand-computed results,
// a negedge monitor pops and compares each time a result is presented.
module tb_normalize_shift_ctrl;
   localparam int W = 55, EW = 11, CW = 6;
   localparam int RW = W + EW + CW + 2;

   logic          clk = 0, rst_n = 0, start_i = 0, ack_i = 0;
   logic [W-1:0]  mant_i = '0;
   logic [EW-1:0] exp_i = '0;
   logic          ready_o, valid_o, zero_o, underflow_o;
   logic [W-1:0]  mant_o;
   logic [EW-1:0] exp_o;
   logic [CW-1:0] shift_o;

   normalize_shift_ctrl #(.W(W), .EW(EW), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .mant_i(mant_i), .exp_i(exp_i),
      .ready_o(ready_o), .valid_o(valid_o), .ack_i(ack_i), .mant_o(mant_o),
      .exp_o(exp_o), .shift_o(shift_o), .zero_o(zero_o), .underflow_o(underflow_o));

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   logic [RW-1:0] sb[$];
   logic [RW-1:0] cur;
   logic          seen = 0;

   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [RW-1:0] pk(input logic [W-1:0] m, input logic [EW-1:0] e,
                                        input logic [CW-1:0] s, input logic z, input logic u);
      return {m, e, s, z, u};
   endfunction

   function automatic logic [W-1:0] bit_at(input int n);
      logic [W-1:0] v;
      v = '0;
      v[n] = 1'b1;
      return v;
   endfunction

   wire [RW-1:0] w_res = {mant_o, exp_o, shift_o, zero_o, underflow_o};

   // Monitor: first valid cycle pops a result, later valid cycles check it is held.
   always @(negedge clk) begin
      if (!rst_n) seen = 0;
      else begin
         if (ready_o && valid_o) check("ready_valid_excl", 1, 0);
         if (valid_o) begin
            if (!seen) begin
               if (sb.size() == 0) check("unexpected_result", w_res, '0);
               else begin
                  cur = sb.pop_front();
                  check("result", w_res, cur);
               end
               seen = 1;
            end else check("held_result", w_res, cur);
         end else seen = 0;
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!ready_o && n < 20) begin @(negedge clk); n++; end
      if (!ready_o) check("ready_timeout", 0, 1);
   endtask

   // Counts edges after the accept edge until valid; two more edges means
   // DONE is the third cycle counting the accept cycle.
   task automatic finish_op(input int ack_wait);
      int cnt = 0;
      while (cnt < 10) begin
         @(posedge clk); #1; cnt++;
         if (valid_o) break;
      end
      check("latency", cnt, 2);
      repeat (ack_wait) @(negedge clk);
      @(negedge clk) ack_i = 1;
      @(posedge clk); #1 ack_i = 0;
      check("ready_after_ack", {ready_o, valid_o}, 2'b10);
   endtask

   task automatic do_op(input logic [W-1:0] m, input logic [EW-1:0] e, input logic [RW-1:0] x,
                        input int ack_wait);
      wait_ready();
      @(negedge clk);
      start_i = 1; mant_i = m; exp_i = e;
      sb.push_back(x);
      @(posedge clk); #1 start_i = 0;
      finish_op(ack_wait);
   endtask

   initial begin
      // reset state
      #2;
      check("reset_hs", {ready_o, valid_o}, 2'b10);
      check("reset_out", w_res, '0);
      @(negedge clk) rst_n = 1;

      do_op(bit_at(54), 11'd1023, pk(bit_at(54), 11'd1023, 6'd0, 0, 0), 0);
      do_op(55'd1, 11'd100, pk(bit_at(54), 11'd46, 6'd54, 0, 0), 0);
      do_op('0, 11'd500, pk('0, 11'd0, 6'd0, 1, 0), 1);
      do_op(bit_at(44), 11'd4, pk(bit_at(48), 11'd0, 6'd4, 0, 1), 0);
      do_op(bit_at(50), 11'd4, pk(bit_at(54), 11'd0, 6'd4, 0, 0), 0);
      do_op(55'd3, 11'd2000, pk(bit_at(54) | bit_at(53), 11'd1947, 6'd53, 0, 0), 2);
      do_op(bit_at(40), 11'd0, pk(bit_at(40), 11'd0, 6'd0, 0, 1), 0);
      do_op('0, 11'd0, pk('0, 11'd0, 6'd0, 1, 0), 0);

      // ack withheld for 5 DONE cycles with start pulses, then held start
      wait_ready();
      @(negedge clk);
      start_i = 1; mant_i = bit_at(44); exp_i = 11'd4;
      sb.push_back(pk(bit_at(48), 11'd0, 6'd4, 0, 1));
      @(posedge clk); #1 start_i = 0;
      repeat (2) @(posedge clk);
      #1 check("done_reached", valid_o, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         start_i = (i % 2 == 0); mant_i = 55'd1; exp_i = 11'd7;
         @(posedge clk); #1;
         check("done_hold_hs", {ready_o, valid_o}, 2'b01);
      end
      @(negedge clk);
      start_i = 1; ack_i = 1; mant_i = bit_at(54); exp_i = 11'd1023;
      sb.push_back(pk(bit_at(54), 11'd1023, 6'd0, 0, 0));
      @(posedge clk); #1 ack_i = 0;
      check("ack_to_idle", {ready_o, valid_o}, 2'b10);
      @(posedge clk); #1 start_i = 0;
      check("held_start_accepted", ready_o, 0);
      finish_op(0);

      // async reset while in SHIFT
      wait_ready();
      @(negedge clk);
      start_i = 1; mant_i = bit_at(20); exp_i = 11'd300;
      @(posedge clk); #1 start_i = 0;
      @(posedge clk); #2 rst_n = 0;
      #1;
      check("rst_mid_hs", {ready_o, valid_o}, 2'b10);
      check("rst_mid_out", w_res, '0);
      repeat (2) @(posedge clk);
      #1 check("rst_hold_hs", {ready_o, valid_o}, 2'b10);
      @(negedge clk) rst_n = 1;
      do_op(55'd1, 11'd100, pk(bit_at(54), 11'd46, 6'd54, 0, 0), 0);

      repeat (3) @(negedge clk);
      check("queue_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end
endmodule
